// File: rtl/qam_pkg.sv
// Shared encodings and helpers for the QAM symbol source: modulation modes,
// FSM states, PRBS-23 polynomial constants and the Gray-to-level mapping.
package qam_pkg;

    localparam int LFSR_LEN = 23;
    localparam int LFSR_TAP = 17;

    typedef enum logic [1:0] {
        MODE_QPSK  = 2'd0,
        MODE_16QAM = 2'd1,
        MODE_64QAM = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Reserved mode falls back to QPSK.
    function automatic logic [2:0] bits_per_sym(input logic [1:0] mode);
        case (mode_e'(mode))
            MODE_16QAM: return 3'd4;
            MODE_64QAM: return 3'd6;
            default:    return 3'd2;
        endcase
    endfunction

    // Gray-decode an m-bit axis word (upper bits zero) to level 2b - (2^m - 1).
    function automatic logic signed [3:0] gray_to_level(input logic [2:0] gray,
                                                        input logic [1:0] m);
        logic [2:0] bin;
        logic [3:0] twice;
        logic [3:0] span;
        bin   = gray ^ (gray >> 1) ^ (gray >> 2);
        twice = {bin, 1'b0};
        span  = (4'd1 << m) - 4'd1;
        return signed'(twice - span);
    endfunction

endpackage

// File: rtl/prbs_par.sv
// PRBS-23 Fibonacci LFSR yielding 2/4/6 bits per step (first bit is the MSB).
// bits is combinational from the current state; the register advances only on step.
module prbs_par
    import qam_pkg::*;
#(
    parameter logic [LFSR_LEN-1:0] SEED = 23'h7FFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [2:0] nbits,
    output logic [5:0] bits
);

    localparam logic [LFSR_LEN-1:0] SEED_EFF = (SEED == '0) ? '1 : SEED;

    logic [LFSR_LEN-1:0] lfsr_q;
    logic [LFSR_LEN-1:0] lfsr_d;
    logic [LFSR_LEN-1:0] walk;
    logic [LFSR_LEN-1:0] s2;
    logic [LFSR_LEN-1:0] s4;
    logic [LFSR_LEN-1:0] s6;
    logic [5:0]          fb;

    always_comb begin
        walk = lfsr_q;
        fb   = '0;
        s2   = lfsr_q;
        s4   = lfsr_q;
        s6   = lfsr_q;
        for (int i = 0; i < 6; i++) begin
            fb[5-i] = walk[LFSR_LEN-1] ^ walk[LFSR_TAP];
            walk    = {walk[LFSR_LEN-2:0], fb[5-i]};
            if (i == 1) s2 = walk;
            if (i == 3) s4 = walk;
            if (i == 5) s6 = walk;
        end
    end

    always_comb begin
        bits   = {4'b0000, fb[5:4]};
        lfsr_d = s2;
        case (nbits)
            3'd4: begin
                bits   = {2'b00, fb[5:2]};
                lfsr_d = s4;
            end
            3'd6: begin
                bits   = fb;
                lfsr_d = s6;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else if (step) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/qam_symbol_source.sv
// PRBS -> QPSK/16/64-QAM Gray mapper -> xUPS upsampler (zero-stuffed or held), registered
// ready/valid output; 1-cycle latency from en, outputs hold while out_ready is low.
module qam_symbol_source
    import qam_pkg::*;
#(
    parameter int                  SYM_W = 4,
    parameter int                  UPS   = 4,
    parameter logic [LFSR_LEN-1:0] SEED  = 23'h7FFFFF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic                    zero_stuff,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [SYM_W-1:0] i_out,
    output logic signed [SYM_W-1:0] q_out,
    output logic                    sym_start,
    output logic [5:0]              bits_out
);

    localparam int              PH_W    = (UPS > 1) ? $clog2(UPS) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPS - 1);

    state_e                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [SYM_W-1:0] sym_i_q, sym_i_d;
    logic signed [SYM_W-1:0] sym_q_q, sym_q_d;
    logic signed [SYM_W-1:0] i_out_q, i_out_d;
    logic signed [SYM_W-1:0] q_out_q, q_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sym_start_q, sym_start_d;
    logic [5:0]              bits_q, bits_d;

    logic                    accept;
    logic                    last_phase;
    logic                    load;
    logic [2:0]              nbits;
    logic [5:0]              word;
    logic [1:0]              m_bits;
    logic [2:0]              gray_i;
    logic [2:0]              gray_q;
    logic signed [3:0]       lvl_i;
    logic signed [3:0]       lvl_q;
    logic signed [SYM_W-1:0] new_i;
    logic signed [SYM_W-1:0] new_q;

    prbs_par #(
        .SEED (SEED)
    ) u_prbs (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (load),
        .nbits (nbits),
        .bits  (word)
    );

    // I takes the upper half of the word, Q the lower half.
    always_comb begin
        nbits  = bits_per_sym(mode);
        m_bits = nbits[2:1];
        gray_i = {2'b00, word[1]};
        gray_q = {2'b00, word[0]};
        case (nbits)
            3'd4: begin
                gray_i = {1'b0, word[3:2]};
                gray_q = {1'b0, word[1:0]};
            end
            3'd6: begin
                gray_i = word[5:3];
                gray_q = word[2:0];
            end
            default: ;
        endcase
        lvl_i = gray_to_level(gray_i, m_bits);
        lvl_q = gray_to_level(gray_q, m_bits);
        new_i = SYM_W'(lvl_i);
        new_q = SYM_W'(lvl_q);
    end

    assign accept     = out_valid_q && out_ready;
    assign last_phase = (phase_q == PH_LAST);
    assign load       = en && ((state_q == ST_IDLE) || (accept && last_phase));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        sym_i_d     = sym_i_q;
        sym_q_d     = sym_q_q;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        out_valid_d = out_valid_q;
        sym_start_d = sym_start_q;
        bits_d      = bits_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (!last_phase) begin
                        phase_d     = phase_q + PH_W'(1);
                        sym_start_d = 1'b0;
                        i_out_d     = zero_stuff ? '0 : sym_i_q;
                        q_out_d     = zero_stuff ? '0 : sym_q_q;
                    end else if (!en) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        sym_start_d = 1'b0;
                        i_out_d     = '0;
                        q_out_d     = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A load overrides the above: new symbol at phase 0 with no bubble.
        if (load) begin
            phase_d     = '0;
            sym_i_d     = new_i;
            sym_q_d     = new_q;
            i_out_d     = new_i;
            q_out_d     = new_q;
            out_valid_d = 1'b1;
            sym_start_d = 1'b1;
            bits_d      = word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
            sym_start_q <= 1'b0;
            bits_q      <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            sym_i_q     <= sym_i_d;
            sym_q_q     <= sym_q_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            out_valid_q <= out_valid_d;
            sym_start_q <= sym_start_d;
            bits_q      <= bits_d;
        end
    end

    assign out_valid = out_valid_q;
    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign sym_start = sym_start_q;
    assign bits_out  = bits_q;

endmodule

// File: tb/tb_qam_symbol_source.sv
// Scoreboard bench for qam_symbol_source: a reference PRBS/mapper model queues expected
// samples whenever a symbol load is requested; a negedge monitor pops them on each accept.
module tb_qam_symbol_source;

    localparam int                 UPS      = 4;
    localparam logic [22:0]        SEED_VAL = 23'h7FFFFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       zero_stuff;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] i_out;
    logic [3:0] q_out;
    logic       sym_start;
    logic [5:0] bits_out;

    always #5 clk = ~clk;

    qam_symbol_source #(
        .SYM_W (4),
        .UPS   (UPS),
        .SEED  (SEED_VAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .zero_stuff (zero_stuff),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .i_out      (i_out),
        .q_out      (q_out),
        .sym_start  (sym_start),
        .bits_out   (bits_out)
    );

    typedef struct packed {
        logic [3:0] i;
        logic [3:0] q;
        logic       st;
        logic [5:0] bits;
    } samp_t;

    samp_t       sb[$];
    logic [22:0] m_lfsr;
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic int lvl(input int g, input int m);
        int acc;
        int b;
        acc = 0;
        b   = 0;
        for (int j = m - 1; j >= 0; j--) begin
            acc = acc ^ ((g >> j) & 1);
            b   = b | (acc << j);
        end
        return 2 * b - ((1 << m) - 1);
    endfunction

    task automatic push_symbol(input logic [1:0] md, input logic zs);
        int          k;
        int          m;
        int          gi;
        int          gq;
        logic        f;
        logic [5:0]  w;
        samp_t       s;
        k = (md == 2'd1) ? 4 : (md == 2'd2) ? 6 : 2;
        m = k / 2;
        w = '0;
        for (int j = 0; j < k; j++) begin
            f      = m_lfsr[22] ^ m_lfsr[17];
            m_lfsr = {m_lfsr[21:0], f};
            w      = {w[4:0], f};
        end
        gi = int'(w) >> m;
        gq = int'(w) & ((1 << m) - 1);
        for (int p = 0; p < UPS; p++) begin
            s.i    = (p == 0 || !zs) ? 4'(lvl(gi, m)) : 4'h0;
            s.q    = (p == 0 || !zs) ? 4'(lvl(gq, m)) : 4'h0;
            s.st   = (p == 0);
            s.bits = w;
            sb.push_back(s);
        end
    endtask

    always @(negedge clk) begin : monitor
        samp_t e;
        samp_t o;
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                vectors++;
                o = {i_out, q_out, sym_start, bits_out};
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_sample: got %h, none expected at %0t", o, $time);
                end else begin
                    e = sb.pop_front();
                    if (o !== e) begin
                        miscompares++;
                        $display("FAIL sample: got i=%h q=%h st=%b bits=%h, want i=%h q=%h st=%b bits=%h at %0t",
                                 o.i, o.q, o.st, o.bits, e.i, e.q, e.st, e.bits, $time);
                    end
                end
            end
            if (en === 1'b1 && (out_valid !== 1'b1 || (out_ready === 1'b1 && sb.size() == 0)))
                push_symbol(mode, zero_stuff);
        end
    end

    task automatic apply_reset(input int cycles);
        @(posedge clk); #2;
        rst_n = 1'b0;
        en    = 1'b0;
        sb.delete();
        m_lfsr = SEED_VAL;
        repeat (cycles) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain(output bit ok);
        @(posedge clk); #2;
        en = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid === 1'b0) begin
                ok = (sb.size() == 0);
                break;
            end
        end
    endtask

    task automatic wait_starts(input int n, output bit ok);
        int seen;
        seen = 0;
        ok   = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && sym_start === 1'b1) seen++;
            if (seen == n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #2;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, i_out, q_out, sym_start, bits_out} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b i=%h q=%h st=%b bits=%h, want all 0",
                     out_valid, i_out, q_out, sym_start, bits_out);
        end
        apply_reset(1);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_qam16_zero_stuff;
        int bubbles;
        bit ok;
        apply_reset(2);
        mode = 2'd1; zero_stuff = 1'b1; out_ready = 1'b1;
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: out_valid=%b before first edge, want 0", out_valid);
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, i_out, q_out, sym_start, bits_out} !== {1'b1, 4'hD, 4'hD, 1'b1, 6'h00}) begin
            miscompares++;
            $display("FAIL first_symbol_16qam: got v=%b i=%h q=%h st=%b bits=%h, want v=1 i=d q=d st=1 bits=00",
                     out_valid, i_out, q_out, sym_start, bits_out);
        end
        @(negedge clk);
        vectors++;
        if ({i_out, q_out, sym_start} !== 9'h0) begin
            miscompares++;
            $display("FAIL zero_stuff_phase1: got i=%h q=%h st=%b, want 0 0 0", i_out, q_out, sym_start);
        end
        bubbles = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b1) bubbles++;
        end
        vectors++;
        if (bubbles != 0) begin
            miscompares++;
            $display("FAIL back_to_back: %0d idle cycles, want 0", bubbles);
        end
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_16qam: stream did not end cleanly, %0d samples outstanding", sb.size());
        end
    endtask

    task automatic test_hold;
        bit ok;
        apply_reset(2);
        mode = 2'd1; zero_stuff = 1'b0; out_ready = 1'b1;
        en = 1'b1;
        @(negedge clk);
        for (int p = 0; p < UPS; p++) begin
            @(negedge clk);
            vectors++;
            if ({sym_start, i_out, q_out} !== {(p == 0), 4'hD, 4'hD}) begin
                miscompares++;
                $display("FAIL hold_phase%0d: got st=%b i=%h q=%h, want st=%b i=d q=d",
                         p, sym_start, i_out, q_out, (p == 0));
            end
        end
        repeat (24) @(negedge clk);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_hold: %0d samples outstanding", sb.size());
        end
    endtask

    task automatic test_modes;
        logic [1:0] mds [3];
        logic [3:0] exp_lvl;
        bit ok;
        mds = '{2'd2, 2'd0, 2'd3};
        for (int t = 0; t < 3; t++) begin
            apply_reset(2);
            mode = mds[t]; zero_stuff = 1'b1; out_ready = 1'b1;
            en = 1'b1;
            exp_lvl = (mds[t] == 2'd2) ? 4'h9 : 4'hF;
            @(negedge clk);
            @(negedge clk);
            vectors++;
            if ({out_valid, i_out, q_out} !== {1'b1, exp_lvl, exp_lvl}) begin
                miscompares++;
                $display("FAIL first_symbol_mode%0d: got v=%b i=%h q=%h, want v=1 i=%h q=%h",
                         mds[t], out_valid, i_out, q_out, exp_lvl, exp_lvl);
            end
            repeat (100) @(negedge clk);
            drain(ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL drain_mode%0d: %0d samples outstanding", mds[t], sb.size());
            end
        end
    endtask

    task automatic test_stall;
        bit ok;
        apply_reset(2);
        mode = 2'd1; zero_stuff = 1'b0; out_ready = 1'b1;
        en = 1'b1;
        wait_starts(6, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_setup: symbol starts not seen in budget");
        end
        @(posedge clk);
        @(posedge clk); #2;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || sb.size() != 2 ||
                {i_out, q_out, sym_start, bits_out} !== sb[0]) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got v=%b i=%h q=%h st=%b bits=%h, want v=1 phase-2 sample %h",
                         c, out_valid, i_out, q_out, sym_start, bits_out, (sb.size() > 0) ? sb[0] : 15'h0);
            end
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (16) @(negedge clk);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_stall: %0d samples outstanding", sb.size());
        end
    endtask

    task automatic test_en_drop;
        int n;
        bit ok;
        mode = 2'd1; zero_stuff = 1'b0; out_ready = 1'b1;
        @(posedge clk); #2;
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #2;
        en = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) n++;
            else break;
        end
        vectors++;
        if (n != 3 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL en_drop: %0d samples after drop (want 3), %0d outstanding (want 0)", n, sb.size());
        end
        @(posedge clk); #2;
        en = 1'b1;
        repeat (20) @(negedge clk);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_en_drop: %0d samples outstanding", sb.size());
        end
    endtask

    task automatic test_mode_toggle;
        logic [2:0] st_seen;
        bit ok;
        mode = 2'd1; zero_stuff = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2;
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        @(posedge clk); #2;
        mode = 2'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            st_seen[c] = sym_start;
        end
        vectors++;
        if (st_seen !== 3'b100) begin
            miscompares++;
            $display("FAIL mode_toggle_boundary: sym_start over 3 cycles (new..old) = %b, want 100", st_seen);
        end
        repeat (20) @(negedge clk);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_toggle: %0d samples outstanding", sb.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        apply_reset(2);
        mode = 2'd1; zero_stuff = 1'b1; out_ready = 1'b1;
        en = 1'b1;
        wait_starts(7, ok);
        @(posedge clk); #2;
        rst_n = 1'b0;
        sb.delete();
        m_lfsr = SEED_VAL;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_valid, i_out, q_out, sym_start, bits_out} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got v=%b i=%h q=%h st=%b bits=%h, want all 0",
                     out_valid, i_out, q_out, sym_start, bits_out);
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, i_out, q_out, sym_start, bits_out} !== {1'b1, 4'hD, 4'hD, 1'b1, 6'h00}) begin
            miscompares++;
            $display("FAIL restart_after_reset: got v=%b i=%h q=%h st=%b bits=%h, want v=1 i=d q=d st=1 bits=00",
                     out_valid, i_out, q_out, sym_start, bits_out);
        end
        repeat (80) @(negedge clk);
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_reset_mid: %0d samples outstanding", sb.size());
        end
    endtask

    task automatic test_random_traffic;
        bit ok;
        zero_stuff = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #2;
            out_ready = ($urandom_range(0, 9) < 7);
            en        = ($urandom_range(0, 9) != 0);
            mode      = 2'($urandom_range(0, 3));
        end
        out_ready = 1'b1;
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drain_random: %0d samples outstanding", sb.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        mode       = 2'd1;
        zero_stuff = 1'b1;
        out_ready  = 1'b1;
        m_lfsr     = SEED_VAL;
        test_reset();
        test_qam16_zero_stuff();
        test_hold();
        test_modes();
        test_stall();
        test_en_drop();
        test_mode_toggle();
        test_reset_mid();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
